// File: rtl/output_accum_buffer.sv
// -----------------------------------------------------------------------------
// output_accum_buffer
//
// Shared 64-entry accumulation buffer on the target side of the
// output-stationary core arbiter. A granted core either adds a burst of
// partial sums into entries 0..B-1 (ADD) or streams entries 0..B-1 out to the
// downstream consumer, clearing each entry as it is read (UNLOAD).
//
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   grant      : one-hot core grant from the arbiter, held for the transfer
//   burst      : beats in the transfer (0..63), sampled in IDLE
//   add_en     : transfer is an accumulate
//   unload_en  : transfer is an unload
//   in_data    : per-core partial-sum lanes, lane i = [i*DATA_W +: DATA_W]
//   in_valid   : per-core beat valid
//   in_ready   : per-core beat ready (only the latched core, only in ADD)
//   out_data   : unload data, combinational from the current entry
//   out_valid  : unload beat valid
//   out_ready  : downstream ready
//   out_core   : core whose unload is in progress
//   busy       : transfer active (ADD, UNLOAD or FIN)
//   done       : one-cycle pulse on normal completion
//   err        : one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module output_accum_buffer #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int CORE_W    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          grant,
  input  logic [5:0]                    burst,
  input  logic                          add_en,
  input  logic                          unload_en,
  input  logic [NUM_CORES*DATA_W-1:0]   in_data,
  input  logic [NUM_CORES-1:0]          in_valid,
  output logic [NUM_CORES-1:0]          in_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CORE_W-1:0]             out_core,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_UNLOAD = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CORE_W-1:0] r_core;
  logic [5:0]        r_burst;
  logic [5:0]        r_k;
  logic              r_done;
  logic              r_err;
  logic [ACC_W-1:0]  r_mem [DEPTH];

  logic              w_done_next;
  logic              w_err_next;
  logic              w_start;

  logic                 w_grant_any;
  logic                 w_grant_onehot;
  logic [CORE_W-1:0]    w_grant_idx;
  logic [NUM_CORES-1:0] w_sel;
  logic                 w_grant_lost;
  logic                 w_req_bad;

  logic [DATA_W-1:0]    w_lanes [NUM_CORES];
  logic [DATA_W-1:0]    w_lane;
  logic [ACC_W-1:0]     w_lane_ext;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_last;

  // ---------------------------------------------------------------------------
  // Lane split and selection of the latched core's lane
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
      assign w_lanes[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_lane     = w_lanes[r_core];
  // Size cast of a signed operand sign-extends to the accumulator width.
  assign w_lane_ext = ACC_W'($signed(w_lane));

  // ---------------------------------------------------------------------------
  // Grant decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_any    = |grant;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    w_grant_onehot = w_grant_any &&
                     ((grant & (grant - NUM_CORES'(1))) == '0);
    w_grant_idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        w_grant_idx = CORE_W'(i);
      end
    end
    w_sel         = '0;
    w_sel[r_core] = 1'b1;
    // Any change away from the latched one-hot, including a drop to zero.
    w_grant_lost  = (grant != w_sel);
    w_req_bad     = !w_grant_onehot || (add_en == unload_en);
  end

  assign w_in_fire  = (r_state == S_ADD) && in_valid[r_core];
  assign w_out_fire = (r_state == S_UNLOAD) && out_ready;
  assign w_last     = (r_k == (r_burst - 6'd1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // done/err are raised only on the transition into FIN, so they pulse once.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          if (w_req_bad) begin
            w_err_next   = 1'b1;
            w_state_next = S_FIN;
          end else begin
            w_start = 1'b1;
            if (burst == 6'd0) begin
              w_done_next  = 1'b1;
              w_state_next = S_FIN;
            end else if (add_en) begin
              w_state_next = S_ADD;
            end else begin
              w_state_next = S_UNLOAD;
            end
          end
        end
      end
      S_ADD: begin
        if (w_grant_lost) begin
          w_err_next   = 1'b1;
          w_state_next = S_FIN;
        end else if (w_in_fire && w_last) begin
          w_done_next  = 1'b1;
          w_state_next = S_FIN;
        end
      end
      S_UNLOAD: begin
        if (w_grant_lost) begin
          w_err_next   = 1'b1;
          w_state_next = S_FIN;
        end else if (w_out_fire && w_last) begin
          w_done_next  = 1'b1;
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        // Wait for the arbiter to release so a held grant cannot retrigger.
        if (!w_grant_any) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_core  = '0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_ADD: begin
        in_ready = w_sel;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = r_mem[r_k];
        out_core  = r_core;
      end
      default: begin
      end
    endcase
  end

  assign done = r_done;
  assign err  = r_err;

  // ---------------------------------------------------------------------------
  // Datapath: latched transfer fields, beat counter and accumulator array.
  // The array is register-based: unload reads the current entry
  // combinationally and reset must clear every entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core  <= '0;
      r_burst <= '0;
      r_k     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_core  <= w_grant_idx;
        r_burst <= burst;
        r_k     <= '0;
      end
      if (w_in_fire) begin
        // Plain modular add: wraps at 2^ACC_W, no saturation.
        r_mem[r_k] <= r_mem[r_k] + w_lane_ext;
        r_k        <= r_k + 6'd1;
      end else if (w_out_fire) begin
        r_mem[r_k] <= '0;
        r_k        <= r_k + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_output_accum_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for output_accum_buffer. A second instance with an 18-bit
// accumulator shares all stimulus so wrap-around is reachable in a few adds.
// -----------------------------------------------------------------------------
module tb_output_accum_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  grant;
  logic [5:0]  burst;
  logic        add_en;
  logic        unload_en;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [1:0]  out_core;
  logic        busy;
  logic        done;
  logic        err;

  logic [3:0]  in_ready_n;
  logic [17:0] out_data_n;
  logic        out_valid_n;
  logic [1:0]  out_core_n;
  logic        busy_n;
  logic        done_n;
  logic        err_n;

  output_accum_buffer #(.NUM_CORES(4), .DATA_W(16), .ACC_W(32), .CORE_W(2)) dut (
    .clk(clk), .reset(reset), .grant(grant), .burst(burst), .add_en(add_en),
    .unload_en(unload_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_core(out_core), .busy(busy), .done(done),
    .err(err)
  );

  output_accum_buffer #(.NUM_CORES(4), .DATA_W(16), .ACC_W(18), .CORE_W(2)) dut_n (
    .clk(clk), .reset(reset), .grant(grant), .burst(burst), .add_en(add_en),
    .unload_en(unload_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_n), .out_data(out_data_n), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_core(out_core_n), .busy(busy_n), .done(done_n),
    .err(err_n)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected accumulator contents.
  logic [31:0] exp_mem [64];
  logic [15:0] add_vals [64];
  logic [4:0]  stall_pat = 5'b11001;  // ready per unload cycle: 1,0,0,1,1

  // Observations from the last transfer.
  int          obs_done, obs_err, obs_done_iter, obs_err_iter;
  int          obs_bad_ready, obs_extra, obs_bad_hold, obs_beats;
  int          obs_bad_core, obs_unstable, obs_last_hs_iter;
  logic        obs_busy_after;
  logic [31:0] got_q [$];
  logic [17:0] got_n_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
  endtask

  task automatic model_add(input int n);
    for (int i = 0; i < n; i++) exp_mem[i] = exp_mem[i] + 32'($signed(add_vals[i]));
  endtask

  task automatic fill_vals(input int n);
    for (int i = 0; i < n; i++) add_vals[i] = 16'($urandom());
  endtask

  // Drives one add-type request and records what the DUT did.
  task automatic drive_add(input logic [3:0] g, input int core, input int b,
                           input logic ae, input logic ue, input int gap_pct,
                           input int drop_after, input int hold);
    int   k;
    logic exp_add;
    obs_done = 0; obs_err = 0; obs_done_iter = -1; obs_err_iter = -1;
    obs_bad_ready = 0; obs_extra = 0; obs_bad_hold = 0;
    exp_add = (g == (4'b0001 << core)) && ae && !ue;
    grant = g; burst = 6'(b); add_en = ae; unload_en = ue; out_ready = 1'b0;
    k = 0;
    for (int it = 0; it < 400; it++) begin
      in_data  = {$urandom(), $urandom()};
      in_valid = 4'($urandom());
      if (drop_after >= 0 && k >= drop_after) begin
        grant = '0; in_valid = '0;
      end else if (k < b && $urandom_range(0, 99) >= gap_pct) begin
        in_valid[core] = 1'b1;
        in_data[core*16 +: 16] = add_vals[k];
      end else begin
        in_valid[core] = 1'b0;
      end
      #1;
      if (in_ready !== ((it >= 1 && exp_add) ? (4'b0001 << core) : 4'b0000)) obs_bad_ready++;
      if (in_ready[core] && in_valid[core]) k++;
      @(posedge clk); #1;
      if (done) begin obs_done++; obs_done_iter = it + 1; end
      if (err)  begin obs_err++;  obs_err_iter  = it + 1; end
      if (done || err) break;
    end
    obs_beats = k;
    for (int h = 0; h < hold; h++) begin
      in_valid = '0; in_valid[core] = 1'b1;
      #1;
      if (in_ready !== 4'b0000 || busy !== 1'b1) obs_bad_hold++;
      tick();
      if (done || err) obs_extra++;
    end
    grant = '0; add_en = 1'b0; unload_en = 1'b0; in_valid = '0;
    tick();
    if (done || err) obs_extra++;
    obs_busy_after = busy;
    $display("xfer add grant=%b burst=%0d beats=%0d done=%0d err=%0d", g, b, k, obs_done, obs_err);
  endtask

  // Drives one unload; mode 0 = always ready, 1 = stall pattern, 2 = random.
  task automatic drive_unload(input int core, input int b, input int mode);
    int          ucyc;
    logic        held;
    logic [31:0] held_data;
    obs_done = 0; obs_err = 0; obs_done_iter = -1; obs_err_iter = -1;
    obs_bad_ready = 0; obs_bad_core = 0; obs_unstable = 0; obs_last_hs_iter = -1;
    got_q.delete(); got_n_q.delete();
    grant = 4'b0001 << core; burst = 6'(b); add_en = 1'b0; unload_en = 1'b1;
    ucyc = 0; held = 1'b0; held_data = '0;
    for (int it = 0; it < 400; it++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ucyc < 5) ? stall_pat[ucyc] : 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_data  = {$urandom(), $urandom()};
      in_valid = 4'($urandom());
      #1;
      if (out_valid !== ((it >= 1) ? 1'b1 : 1'b0)) obs_bad_ready++;
      if (in_ready !== 4'b0000) obs_bad_ready++;
      if (out_valid) begin
        if (out_core !== 2'(core)) obs_bad_core++;
        if (held && out_data !== held_data) obs_unstable++;
        if (out_ready) begin
          got_q.push_back(out_data);
          got_n_q.push_back(out_data_n);
          obs_last_hs_iter = it;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = out_data;
        end
        ucyc++;
      end
      @(posedge clk); #1;
      if (done) begin obs_done++; obs_done_iter = it + 1; end
      if (err)  begin obs_err++;  obs_err_iter  = it + 1; end
      if (done || err) break;
    end
    grant = '0; unload_en = 1'b0; out_ready = 1'b0; in_valid = '0;
    tick();
    obs_busy_after = busy;
    $display("xfer unload core=%0d burst=%0d beats=%0d done=%0d err=%0d", core, b, got_q.size(), obs_done, obs_err);
  endtask

  task automatic do_reset();
    reset = 1'b1; grant = '0; burst = '0; add_en = 1'b0; unload_en = 1'b0;
    in_data = '0; in_valid = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    model_clear();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; grant = 4'b0010; burst = 6'd5; add_en = 1'b1; unload_en = 1'b0;
    in_data = '1; in_valid = '1; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, out_core, busy, done, err} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {in_ready, out_valid, out_core, busy, done, err});
    end
    checks++;
    if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    grant = '0; add_en = 1'b0; in_valid = '0; out_ready = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, busy, done, err} !== 8'd0) begin
      errors++; $display("FAIL idle_ctrl: got %b expected 0", {in_ready, out_valid, busy, done, err});
    end
    model_clear();
    $display("xfer reset");
  endtask

  task automatic test_add_basic();
    add_vals[0] = 16'd5; add_vals[1] = 16'hFFFE; add_vals[2] = 16'd7;
    drive_add(4'b0010, 1, 3, 1'b1, 1'b0, 0, -1, 1);
    model_add(3);
    checks++; if (obs_done !== 1) begin errors++; $display("FAIL add_basic_done: got %0d expected 1", obs_done); end
    checks++; if (obs_done_iter !== 4) begin errors++; $display("FAIL add_basic_latency: got %0d expected 4", obs_done_iter); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL add_basic_err: got %0d expected 0", obs_err); end
    checks++; if (obs_bad_ready !== 0) begin errors++; $display("FAIL add_basic_in_ready: bad cycles %0d expected 0", obs_bad_ready); end
    checks++; if (obs_extra !== 0 || obs_bad_hold !== 0) begin
      errors++; $display("FAIL add_basic_single_pulse: extra %0d hold %0d expected 0", obs_extra, obs_bad_hold); end
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL add_basic_idle: busy %b expected 0", obs_busy_after); end
  endtask

  task automatic test_add_core3();
    add_vals[0] = 16'd2; add_vals[1] = 16'd3; add_vals[2] = 16'd4;
    drive_add(4'b1000, 3, 3, 1'b1, 1'b0, 40, -1, 0);
    model_add(3);
    checks++; if (obs_done !== 1 || obs_err !== 0 || obs_beats !== 3) begin
      errors++; $display("FAIL add_core3: done %0d err %0d beats %0d expected 1 0 3", obs_done, obs_err, obs_beats); end
    checks++; if (obs_bad_ready !== 0) begin errors++; $display("FAIL add_core3_in_ready: bad cycles %0d expected 0", obs_bad_ready); end
  endtask

  task automatic test_unload_basic();
    logic [31:0] lit [3];
    lit[0] = 32'd7; lit[1] = 32'd1; lit[2] = 32'd11;
    drive_unload(0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== lit[i] || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL unload_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, lit[i]); end
      exp_mem[i] = '0;
    end
    checks++; if (obs_done !== 1 || obs_bad_core !== 0 || obs_bad_ready !== 0) begin
      errors++; $display("FAIL unload_ctrl: done %0d bad_core %0d bad_valid %0d expected 1 0 0", obs_done, obs_bad_core, obs_bad_ready); end
    drive_unload(0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== 32'd0) begin
        errors++; $display("FAIL unload_cleared[%0d]: got %h expected 0", i, (i < got_q.size()) ? got_q[i] : 32'hx); end
    end
  endtask

  task automatic test_unload_stall();
    fill_vals(3);
    drive_add(4'b0100, 2, 3, 1'b1, 1'b0, 0, -1, 0);
    model_add(3);
    drive_unload(1, 3, 1);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL stall_handshakes: got %0d expected 3", got_q.size()); end
    checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL stall_stable: changes %0d expected 0", obs_unstable); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
      exp_mem[i] = '0;
    end
    checks++; if (obs_done !== 1 || obs_done_iter !== 6 || obs_done_iter !== obs_last_hs_iter + 1) begin
      errors++; $display("FAIL stall_done: done %0d at %0d last_hs %0d expected 1 at 6", obs_done, obs_done_iter, obs_last_hs_iter); end
  endtask

  task automatic test_random();
    int core, b;
    for (int r = 0; r < 8; r++) begin
      core = $urandom_range(0, 3);
      b    = $urandom_range(1, 63);
      fill_vals(b);
      drive_add(4'b0001 << core, core, b, 1'b1, 1'b0, 25, -1, 0);
      model_add(b);
      checks++; if (obs_done !== 1 || obs_err !== 0 || obs_beats !== b || obs_bad_ready !== 0) begin
        errors++; $display("FAIL rand_add[%0d]: done %0d err %0d beats %0d bad_ready %0d expected 1 0 %0d 0", r, obs_done, obs_err, obs_beats, obs_bad_ready, b); end
      if (r % 3 == 2) begin
        b = $urandom_range(1, 63);
        drive_unload(core, b, 2);
        checks++; if (obs_unstable !== 0 || obs_bad_core !== 0 || got_q.size() !== b) begin
          errors++; $display("FAIL rand_unload_ctrl[%0d]: unstable %0d bad_core %0d beats %0d expected 0 0 %0d", r, obs_unstable, obs_bad_core, got_q.size(), b); end
        for (int i = 0; i < b; i++) begin
          checks++;
          if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
            errors++; $display("FAIL rand_unload[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
          exp_mem[i] = '0;
        end
      end
    end
    drive_unload(2, 63, 0);
    for (int i = 0; i < 63; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL rand_final[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
      exp_mem[i] = '0;
    end
  endtask

  task automatic test_burst0();
    fill_vals(4);
    drive_add(4'b0001, 0, 4, 1'b1, 1'b0, 0, -1, 0);
    model_add(4);
    fill_vals(4);
    drive_add(4'b0010, 1, 0, 1'b1, 1'b0, 0, -1, 0);
    checks++; if (obs_done !== 1 || obs_done_iter !== 1 || obs_err !== 0) begin
      errors++; $display("FAIL burst0: done %0d at %0d err %0d expected 1 at 1, 0", obs_done, obs_done_iter, obs_err); end
    checks++; if (obs_bad_ready !== 0) begin errors++; $display("FAIL burst0_in_ready: bad cycles %0d expected 0", obs_bad_ready); end
    drive_unload(3, 4, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL burst0_mem[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
      exp_mem[i] = '0;
    end
  endtask

  task automatic test_errors();
    logic [3:0] g_tab  [3];
    logic       ae_tab [3];
    logic       ue_tab [3];
    g_tab[0] = 4'b0110; ae_tab[0] = 1'b1; ue_tab[0] = 1'b0;
    g_tab[1] = 4'b0001; ae_tab[1] = 1'b1; ue_tab[1] = 1'b1;
    g_tab[2] = 4'b0100; ae_tab[2] = 1'b0; ue_tab[2] = 1'b0;
    fill_vals(3);
    for (int t = 0; t < 3; t++) begin
      drive_add(g_tab[t], 1, 3, ae_tab[t], ue_tab[t], 0, -1, 2);
      checks++; if (obs_err !== 1 || obs_err_iter !== 1 || obs_done !== 0) begin
        errors++; $display("FAIL err_case[%0d]: err %0d at %0d done %0d expected 1 at 1, 0", t, obs_err, obs_err_iter, obs_done); end
      checks++; if (obs_bad_ready !== 0 || obs_extra !== 0 || obs_bad_hold !== 0 || obs_busy_after !== 1'b0) begin
        errors++; $display("FAIL err_case_ctrl[%0d]: bad_ready %0d extra %0d hold %0d busy %b expected 0", t, obs_bad_ready, obs_extra, obs_bad_hold, obs_busy_after); end
    end
  endtask

  task automatic test_abort();
    fill_vals(5);
    drive_add(4'b0010, 1, 5, 1'b1, 1'b0, 0, -1, 0);
    model_add(5);
    fill_vals(5);
    drive_add(4'b0010, 1, 5, 1'b1, 1'b0, 0, 2, 0);
    model_add(2);
    checks++; if (obs_err !== 1 || obs_done !== 0 || obs_beats !== 2) begin
      errors++; $display("FAIL abort: err %0d done %0d beats %0d expected 1 0 2", obs_err, obs_done, obs_beats); end
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b expected 0", obs_busy_after); end
    drive_unload(0, 5, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL abort_mem[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
      exp_mem[i] = '0;
    end
  endtask

  task automatic test_held_grant();
    fill_vals(2);
    drive_add(4'b1000, 3, 2, 1'b1, 1'b0, 0, -1, 8);
    model_add(2);
    checks++; if (obs_done !== 1 || obs_extra !== 0 || obs_bad_hold !== 0) begin
      errors++; $display("FAIL held_grant: done %0d extra %0d bad_hold %0d expected 1 0 0", obs_done, obs_extra, obs_bad_hold); end
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL held_grant_release: busy %b expected 0", obs_busy_after); end
    drive_unload(3, 2, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL held_grant_mem[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
      exp_mem[i] = '0;
    end
  endtask

  task automatic test_wrap();
    logic [17:0] exp_n;
    do_reset();
    exp_n = '0;
    add_vals[0] = 16'h8000;
    for (int r = 0; r < 5; r++) begin
      drive_add(4'b0001, 0, 1, 1'b1, 1'b0, 0, -1, 0);
      model_add(1);
      exp_n = exp_n + 18'($signed(16'h8000));
    end
    drive_unload(0, 1, 0);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_mem[0]) begin
      errors++; $display("FAIL wrap_acc32: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 32'hx, exp_mem[0]); end
    checks++;
    if (got_n_q.size() !== 1 || got_n_q[0] !== exp_n) begin
      errors++; $display("FAIL wrap_acc18: got %h expected %h", (got_n_q.size() > 0) ? got_n_q[0] : 18'hx, exp_n); end
    exp_mem[0] = '0;
  endtask

  task automatic test_reset_abort();
    int pulses;
    fill_vals(3);
    drive_add(4'b0001, 0, 3, 1'b1, 1'b0, 0, -1, 0);
    model_add(3);
    pulses = 0;
    grant = 4'b0100; burst = 6'd6; add_en = 1'b1; unload_en = 1'b0;
    in_valid = 4'b0100; in_data = '0; in_data[32 +: 16] = 16'h0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || err) pulses++;
    end
    reset = 1'b1;
    tick();
    if (done || err) pulses++;
    reset = 1'b0; grant = '0; add_en = 1'b0; in_valid = '0;
    tick();
    if (done || err) pulses++;
    checks++; if (pulses !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_abort: pulses %0d busy %b expected 0 0", pulses, busy); end
    $display("xfer reset mid-transfer");
    model_clear();
    drive_unload(1, 63, 0);
    for (int i = 0; i < 63; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_mem[i]) begin
        errors++; $display("FAIL reset_abort_mem[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_core3();
    test_unload_basic();
    test_unload_stall();
    test_random();
    test_burst0();
    test_errors();
    test_abort();
    test_held_grant();
    test_wrap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
